vga_plot_capture: RTL and testbench
===================================

# vga_plot_capture

Receiving end of the pixel-plot stream (`VGA_X`/`VGA_Y`/`VGA_COLOUR`/`VGA_PLOT`) that drawing blocks emit toward the VGA adapter. It accepts plot commands, writes them into an on-chip 160×120×3-bit framebuffer shadow, and exposes a synchronous readback port plus plot/error counters. It sits alongside the adapter in lab top levels and benches, so a screen's contents can be checked pixel-by-pixel without decoding VGA timing.

## Interface

Parameters:
- `WIDTH`, 160: visible columns.
- `HEIGHT`, 120: visible rows.
- `COLOUR_BITS`, 3: bits per pixel.

Ports:
- `CLOCK_50` in 1: sole clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `VGA_X` in 8: plot column.
- `VGA_Y` in 7: plot row.
- `VGA_COLOUR` in 3: plot colour.
- `VGA_PLOT` in 1: plot strobe; one pixel per cycle high.
- `clear` in 1: single-cycle request to zero the framebuffer.
- `busy` out 1: high while clearing.
- `rd_en` in 1: readback request.
- `rd_x` in 8: readback column.
- `rd_y` in 7: readback row.
- `rd_colour` out 3: readback data.
- `rd_valid` out 1: `rd_colour` valid this cycle.
- `plot_count` out 16: accepted in-range writes, saturating.
- `oob_count` out 8: out-of-range plots, saturating.
- `drop_count` out 8: plots discarded while busy, saturating.
- `oob_flag` out 1: sticky, set on the first out-of-range plot.

## Operation

- **States:** `CLEAR` and `RUN`.
- **Reset:**
  - State becomes `CLEAR` with the clear address at 0.
  - All counters, `oob_flag`, `rd_valid` and `rd_colour` go to 0.
  - `busy` is 1.
- **CLEAR:**
  - Writes 0 to address `clr_addr`, then increments it, one address per cycle.
  - After writing address 19199, moves to `RUN`.
  - Asserting `clear` while already in `CLEAR` restarts from address 0.
  - Plots arriving in `CLEAR` are not written; each one increments `drop_count`. They are not counted as OOB.
- **RUN:**
  - A plot is in range when `VGA_X < WIDTH` and `VGA_Y < HEIGHT`.
  - In-range plot: write the colour to address `VGA_Y*160 + VGA_X` (15-bit unsigned; products and sums are computed at 15 bits) and increment `plot_count`.
  - Out-of-range plot: no write; increment `oob_count` and set `oob_flag`.
  - `clear` high in `RUN`: go to `CLEAR` at address 0.
  - `clear` has priority over a same-cycle plot; that plot counts as dropped.
- **Counters:**
  - Saturate at all-ones.
  - `plot_count`, `oob_count` and `drop_count` are zeroed by `reset` and on entry to `CLEAR` via `clear`.
  - `oob_flag` is cleared only by `reset`.
- **Readback:**
  - `rd_en` with in-range coordinates returns the stored colour.
  - Out-of-range read coordinates return 0.
  - A read whose request cycle is in `CLEAR` returns 0.
  - `rd_valid` is asserted in every response case.
- **Read/write collision:** a same-address read and write in the same cycle returns the old data (read-before-write).

## Timing

- Clear takes exactly 19200 cycles:
  - `busy` rises the cycle after `reset` or `clear` is sampled.
  - `busy` falls the cycle after address 19199 is written.
- Plot write is visible to a read issued in the next cycle or later.
- Read latency is 1:
  - `rd_en` sampled at edge N gives `rd_colour`/`rd_valid` valid after edge N+1.
  - `rd_valid` is high for exactly one cycle per request.
  - Back-to-back reads give back-to-back responses.
- Counters and `oob_flag` update one cycle after the plot is sampled.

## Structure

- Package `vga_cap_pkg` holds:
  - `WIDTH`, `HEIGHT` and `FB_DEPTH` (= 19200).
  - `ADDR_W` (= 15).
  - The state enum `cap_state_t` (`CLEAR`, `RUN`).
  - Function `pix_addr(x, y)`.
- Sub-module `fb_ram`:
  - Simple dual-port, 19200×3.
  - One write port and one synchronous read port, with read-before-write behaviour.
  - Coded for M10K inference.
- FSM, counters and range checks live in `vga_plot_capture`.

## Test plan

1. **Reset clear:** pulse `reset` → `busy` high for exactly 19200 cycles; then reading (0,0) and (159,119) returns 0 with `rd_valid` one cycle later; all counters are 0.
2. **Basic write/read:** in `RUN`, plot (5,7) colour 5 → `plot_count`=1; reading (5,7) next cycle returns 5; reading (6,7) returns 0.
3. **Out-of-range plots:** plot (160,0) and (0,120) colour 7 → `oob_count`=2, `oob_flag`=1, `plot_count` unchanged; reading (0,0) returns 0.
4. **Collision:** same-cycle plot (10,10) colour 2 and read (10,10) → returns 0; a read next cycle returns 2.
5. **Clear with plots:** `clear` mid-run with 3 plots during `CLEAR` → `drop_count`=3; after `busy` falls, the earlier pixel (5,7) reads 0 and `oob_flag` is still 1.
6. **Reset during clear:** `reset` at cycle 10000 of a clear → restarts; `busy` stays high a further 19200 cycles; `oob_flag`=0.
7. **Counter saturation:** 70000 in-range plots → `plot_count` holds at 65535.

Source files
------------

// File: rtl/vga_cap_pkg.sv
// Shared constants, state type and address helper for the plot capture block.
// Framebuffer is row-major: addr = y*160 + x.
package vga_cap_pkg;

    localparam int WIDTH       = 160;
    localparam int HEIGHT      = 120;
    localparam int FB_DEPTH    = 19200;
    localparam int ADDR_W      = 15;
    localparam int COLOUR_BITS = 3;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } cap_state_t;

    // Row-major pixel address, computed at 15 bits.
    function automatic logic [ADDR_W-1:0] pix_addr(
        input logic [7:0] x,
        input logic [6:0] y
    );
        logic [ADDR_W-1:0] xa;
        logic [ADDR_W-1:0] ya;
        xa = ADDR_W'(x);
        ya = ADDR_W'(y);
        return ya * ADDR_W'(WIDTH) + xa;
    endfunction

endpackage

// File: rtl/vga_plot_capture_if.sv
// Pixel-plot stream as emitted by drawing blocks toward the VGA adapter.
// The drawing block is the master; the capture block is the slave.
interface vga_plot_capture_if;
    import vga_cap_pkg::*;

    logic [7:0]             VGA_X;
    logic [6:0]             VGA_Y;
    logic [COLOUR_BITS-1:0] VGA_COLOUR;
    logic                   VGA_PLOT;

    modport master (output VGA_X, output VGA_Y, output VGA_COLOUR, output VGA_PLOT);
    modport slave  (input  VGA_X, input  VGA_Y, input  VGA_COLOUR, input  VGA_PLOT);

endinterface

// File: rtl/fb_ram.sv
// Simple dual-port framebuffer RAM, one write port, one registered read port.
// Read returns the pre-write contents on a same-address collision.
module fb_ram #(
    parameter int DEPTH = 19200,
    parameter int AW    = 15,
    parameter int DW    = 3
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Write and registered read share one edge; NBA ordering gives old data.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/vga_plot_capture.sv
// Captures VGA plot commands into a 160x120x3 framebuffer shadow with
// readback, a self-clearing sequencer and saturating plot/oob/drop counters.
module vga_plot_capture #(
    parameter int WIDTH       = 160,
    parameter int HEIGHT      = 120,
    parameter int COLOUR_BITS = 3
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    vga_plot_capture_if.slave      plot,
    input  logic                   clear,
    output logic                   busy,
    input  logic                   rd_en,
    input  logic [7:0]             rd_x,
    input  logic [6:0]             rd_y,
    output logic [COLOUR_BITS-1:0] rd_colour,
    output logic                   rd_valid,
    output logic [15:0]            plot_count,
    output logic [7:0]             oob_count,
    output logic [7:0]             drop_count,
    output logic                   oob_flag
);
    import vga_cap_pkg::*;

    cap_state_t             state;
    logic [ADDR_W-1:0]      clr_addr;
    logic                   plot_in;
    logic                   rd_in;
    logic                   rd_ok;
    logic                   we;
    logic [ADDR_W-1:0]      waddr;
    logic [COLOUR_BITS-1:0] wdata;
    logic [COLOUR_BITS-1:0] ram_q;
    logic                   rd_zero;

    assign plot_in = (plot.VGA_X < 8'(WIDTH)) && (plot.VGA_Y < 7'(HEIGHT));
    assign rd_in   = (rd_x < 8'(WIDTH)) && (rd_y < 7'(HEIGHT));
    assign rd_ok   = rd_en && rd_in && (state == RUN);
    assign busy    = (state == CLEAR);

    // Write port mux: clear sweep owns the RAM in CLEAR, plots in RUN.
    always_comb begin
        we    = 1'b0;
        waddr = clr_addr;
        wdata = '0;
        if (!reset) begin
            if (state == CLEAR) begin
                we = 1'b1;
            end else if (plot.VGA_PLOT && plot_in && !clear) begin
                we    = 1'b1;
                waddr = pix_addr(plot.VGA_X, plot.VGA_Y);
                wdata = plot.VGA_COLOUR;
            end
        end
    end

    // Sequencer and counters; clear wins over a same-cycle plot.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state      <= CLEAR;
            clr_addr   <= '0;
            plot_count <= '0;
            oob_count  <= '0;
            drop_count <= '0;
            oob_flag   <= 1'b0;
        end else if (clear) begin
            state      <= CLEAR;
            clr_addr   <= '0;
            plot_count <= '0;
            oob_count  <= '0;
            drop_count <= plot.VGA_PLOT ? 8'd1 : 8'd0;
        end else begin
            unique case (state)
                CLEAR: begin
                    if (plot.VGA_PLOT && drop_count != '1) begin
                        drop_count <= drop_count + 8'd1;
                    end
                    if (clr_addr == ADDR_W'(FB_DEPTH - 1)) begin
                        state    <= RUN;
                        clr_addr <= '0;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end
                RUN: begin
                    if (plot.VGA_PLOT) begin
                        if (plot_in) begin
                            if (plot_count != '1) begin
                                plot_count <= plot_count + 16'd1;
                            end
                        end else begin
                            oob_flag <= 1'b1;
                            if (oob_count != '1) begin
                                oob_count <= oob_count + 8'd1;
                            end
                        end
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    // Read response: one-cycle valid; zero for bad coords or reads during CLEAR.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_zero  <= 1'b1;
        end else begin
            rd_valid <= rd_en;
            rd_zero  <= !rd_ok;
        end
    end

    assign rd_colour = rd_zero ? '0 : ram_q;

    fb_ram #(
        .DEPTH (FB_DEPTH),
        .AW    (ADDR_W),
        .DW    (COLOUR_BITS)
    ) u_fb (
        .clk   (CLOCK_50),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .re    (rd_ok),
        .raddr (pix_addr(rd_x, rd_y)),
        .rdata (ram_q)
    );

endmodule

// File: tb/tb_vga_plot_capture.sv
// Randomised scoreboard bench for vga_plot_capture against a 2-D array model.
// Read responses are queued at issue time and checked by a separate monitor.
module tb_vga_plot_capture;

    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic        busy;
    logic        rd_en = 1'b0;
    logic [7:0]  rd_x = '0;
    logic [6:0]  rd_y = '0;
    logic [2:0]  rd_colour;
    logic        rd_valid;
    logic [15:0] plot_count;
    logic [7:0]  oob_count;
    logic [7:0]  drop_count;
    logic        oob_flag;

    vga_plot_capture_if pif ();

    vga_plot_capture dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .plot       (pif.slave),
        .clear      (clear),
        .busy       (busy),
        .rd_en      (rd_en),
        .rd_x       (rd_x),
        .rd_y       (rd_y),
        .rd_colour  (rd_colour),
        .rd_valid   (rd_valid),
        .plot_count (plot_count),
        .oob_count  (oob_count),
        .drop_count (drop_count),
        .oob_flag   (oob_flag)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int total = 0;
    int bad = 0;

    // Reference model: screen as a 2-D array plus plain integer counters.
    int fb [160][120];
    bit m_run = 1'b0;
    int m_plot = 0;
    int m_oob = 0;
    int m_drop = 0;
    bit m_flag = 1'b0;
    int exp_q [$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic model_wipe();
        foreach (fb[i, j]) fb[i][j] = 0;
    endtask

    // Drive one cycle of stimulus and update the model with its effect.
    task automatic cyc(input bit p, input int x, input int y, input int c,
                       input bit r, input int rx, input int ry, input bit clr);
        pif.VGA_PLOT   = p;
        pif.VGA_X      = 8'(x);
        pif.VGA_Y      = 7'(y);
        pif.VGA_COLOUR = 3'(c);
        rd_en          = r;
        rd_x           = 8'(rx);
        rd_y           = 7'(ry);
        clear          = clr;
        if (r) begin
            if (m_run && rx < 160 && ry < 120) exp_q.push_back(fb[rx][ry]);
            else exp_q.push_back(0);
        end
        if (clr) begin
            m_run  = 1'b0;
            m_plot = 0;
            m_oob  = 0;
            m_drop = p ? 1 : 0;
            model_wipe();
        end else if (p) begin
            if (!m_run) begin
                if (m_drop < 255) m_drop++;
            end else if (x < 160 && y < 120) begin
                fb[x][y] = c;
                if (m_plot < 65535) m_plot++;
            end else begin
                m_flag = 1'b1;
                if (m_oob < 255) m_oob++;
            end
        end
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, "_plot_count"}, int'(plot_count), m_plot);
        chk({tag, "_oob_count"}, int'(oob_count), m_oob);
        chk({tag, "_drop_count"}, int'(drop_count), m_drop);
        chk({tag, "_oob_flag"}, int'(oob_flag), int'(m_flag));
    endtask

    // Count busy cycles after a reset/clear edge; bounded so it cannot hang.
    task automatic wait_clear(input string tag);
        int n;
        n = 0;
        while (busy && n < 30000) begin
            @(posedge CLOCK_50);
            #1;
            n++;
        end
        chk({tag, "_busy_cycles"}, n, 19200);
        m_run = 1'b1;
    endtask

    // Monitor: every response pops the oldest outstanding read expectation.
    always @(negedge CLOCK_50) begin
        if (rd_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rd_unexpected got=%0d want=none", rd_colour);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (int'(rd_colour) != e) begin
                    bad++;
                    $display("FAIL rd_colour got=%0d want=%0d", rd_colour, e);
                end
            end
        end
    end

    initial begin
        int x;
        int y;
        int rx;
        int ry;
        pif.VGA_PLOT = 1'b0;
        pif.VGA_X = '0;
        pif.VGA_Y = '0;
        pif.VGA_COLOUR = '0;
        model_wipe();

        // Reset, then re-reset part-way through the sweep: must restart.
        idle();
        reset = 1'b0;
        chk("busy_after_reset", int'(busy), 1);
        chk_counters("reset");
        repeat (200) idle();
        chk("busy_mid_clear", int'(busy), 1);
        reset = 1'b1;
        idle();
        reset = 1'b0;
        chk("busy_after_rereset", int'(busy), 1);
        wait_clear("reset");
        chk_counters("after_clear");
        chk("rd_valid_idle", int'(rd_valid), 0);

        // Corners read back as zero.
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 159, 119, 0);
        idle();

        // Basic write and neighbouring read.
        cyc(1, 5, 7, 5, 0, 0, 0, 0);
        chk("basic_plot_count", int'(plot_count), 1);
        cyc(0, 0, 0, 0, 1, 5, 7, 0);
        cyc(0, 0, 0, 0, 1, 6, 7, 0);

        // Out-of-range plots on each axis.
        cyc(1, 160, 0, 7, 0, 0, 0, 0);
        cyc(1, 0, 120, 7, 0, 0, 0, 0);
        chk_counters("oob");
        cyc(0, 0, 0, 0, 1, 0, 0, 0);

        // Same-cycle write/read collision, then the follow-up read.
        cyc(1, 10, 10, 2, 1, 10, 10, 0);
        cyc(0, 0, 0, 0, 1, 10, 10, 0);

        // Last pixel and far out-of-range reads.
        cyc(1, 159, 119, 6, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 159, 119, 0);
        cyc(0, 0, 0, 0, 1, 255, 127, 0);
        cyc(0, 0, 0, 0, 1, 160, 5, 0);
        idle();
        chk_counters("edges");

        // Random mixed traffic in a small window so reads hit written pixels.
        for (int i = 0; i < 600; i++) begin
            x  = ($urandom % 8 == 0) ? int'($urandom_range(160, 255)) : int'($urandom_range(0, 15));
            y  = ($urandom % 8 == 0) ? int'($urandom_range(120, 127)) : int'($urandom_range(0, 15));
            rx = ($urandom % 8 == 0) ? int'($urandom_range(150, 200)) : int'($urandom_range(0, 15));
            ry = int'($urandom_range(0, 15));
            cyc(($urandom % 4) != 0, x, y, int'($urandom_range(0, 7)),
                ($urandom % 2) != 0, rx, ry, 0);
        end
        idle();
        chk_counters("random");

        // Saturate oob_count.
        for (int i = 0; i < 300; i++) begin
            cyc(1, int'($urandom_range(160, 255)), int'($urandom_range(0, 127)), 1, 0, 0, 0, 0);
        end
        chk("oob_saturate", int'(oob_count), 255);

        // Saturate plot_count.
        for (int i = 0; i < 65540; i++) begin
            cyc(1, int'($urandom_range(0, 159)), int'($urandom_range(0, 119)),
                int'($urandom_range(0, 7)), 0, 0, 0, 0);
        end
        chk("plot_saturate", int'(plot_count), 65535);
        cyc(0, 0, 0, 0, 1, 5, 7, 0);

        // Clear from RUN: counters zero, flag sticky, plots dropped, reads zero.
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        chk("busy_after_clear", int'(busy), 1);
        chk_counters("clear");
        for (int i = 0; i < 3; i++) begin
            cyc(1, int'($urandom_range(0, 159)), int'($urandom_range(0, 119)), 3, 1, 5, 7, 0);
        end
        chk("drop_three", int'(drop_count), 3);
        for (int i = 0; i < 300; i++) begin
            cyc(1, int'($urandom_range(0, 255)), int'($urandom_range(0, 127)), 4, 0, 0, 0, 0);
        end
        chk_counters("drop_sat");
        idle();
        idle();
        chk("pending_reads", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
